// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Shares the coprocessor's single memory port between NUM_REQ requesters
//   (requester 0 is the main control unit, the rest are processing units).
//   Requesters use a level request / registered grant handshake with
//   round-robin fairness. Every change of ownership passes through one
//   HANDOVER cycle with the bus forced to zero, so two owners never drive the
//   bus in the same cycle.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, an owner that has held the bus for MAX_HOLD cycles is
//     preempted if any other requester is waiting. When undefined, the owner
//     keeps the bus until it drops its request and MAX_HOLD has no effect.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   ADDR_W    memory address width
//   DATA_W    memory data width
//   MAX_HOLD  maximum consecutive grant cycles under ARB_TIMEOUT_EN (>= 2)
//
// Ports
//   i_Clock           system clock, rising edge
//   i_Reset           synchronous active-high reset
//   i_Grant_Request   per-requester level request, held for the transaction
//   o_Grant           registered one-hot grant
//   o_Grant_Valid     high while any grant is active
//   o_Grant_Index     index of the current owner, 0 when no grant
//   i_Address         packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   i_Write_Enable    per-requester write strobe
//   i_Write_Data      packed write data, requester k at [k*DATA_W +: DATA_W]
//   o_Memory_Address  owner's address, 0 outside GRANT
//   o_Write_Enable    owner's write strobe, 0 outside GRANT
//   o_Memory_Data     owner's write data, 0 outside GRANT
//   o_Memory_Drive    tristate enable for o_Memory_Data
module memory_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [NUM_REQ-1:0]        i_Grant_Request,
  output logic [NUM_REQ-1:0]        o_Grant,
  output logic                      o_Grant_Valid,
  output logic [2:0]                o_Grant_Index,
  input  logic [NUM_REQ*ADDR_W-1:0] i_Address,
  input  logic [NUM_REQ-1:0]        i_Write_Enable,
  input  logic [NUM_REQ*DATA_W-1:0] i_Write_Data,
  output logic [ADDR_W-1:0]         o_Memory_Address,
  output logic                      o_Write_Enable,
  output logic [DATA_W-1:0]         o_Memory_Data,
  output logic                      o_Memory_Drive
);

  localparam int unsigned IDX_W = 3;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("memory_bus_arbiter: NUM_REQ must be in 2..8");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("memory_bus_arbiter: MAX_HOLD must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT    = 2'b01,
    ST_HANDOVER = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   ptr_next;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  logic               owner_req;
  logic               preempt;
  logic               release_bus;

  // Requests are sampled into a register first; arbitration and owner
  // release both act on this sampled copy, giving the one-cycle request to
  // grant pipeline.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      req_q <= '0;
    end else begin
      req_q <= i_Grant_Request;
    end
  end

  // Round-robin pick: first scan from the pointer up to NUM_REQ-1, then
  // wrap and scan from 0 up to the pointer. Two fixed-index passes keep
  // every select constant after unrolling.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_q[k] && (IDX_W'(k) >= ptr_q)) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_q[k] && (IDX_W'(k) < ptr_q)) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pick_onehot[k] = pick_found && (pick_idx == IDX_W'(k));
    end
  end

  // grant_q is one-hot, so masking the sampled requests isolates the owner.
  assign owner_req = |(req_q & grant_q);
  assign ptr_next  = (index_q == IDX_W'(NUM_REQ - 1)) ? '0 : index_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              others_pending;

  assign others_pending = |(req_q & ~grant_q);
  // Firing at MAX_HOLD-1 revokes the grant at the following edge, so the
  // owner has exactly MAX_HOLD visible grant cycles.
  assign preempt = (hold_q == HOLD_W'(MAX_HOLD - 1)) && others_pending;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  assign release_bus = !owner_req || preempt;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    index_d = index_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          grant_d = pick_onehot;
          valid_d = 1'b1;
          index_d = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_bus) begin
          state_d = ST_HANDOVER;
          grant_d = '0;
          valid_d = 1'b0;
          index_d = '0;
          ptr_d   = ptr_next;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      ST_HANDOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        index_d = '0;
      end
    endcase
  end

  assign o_Grant       = grant_q;
  assign o_Grant_Valid = valid_q;
  assign o_Grant_Index = index_q;

  // Bus mux keyed on the registered owner index; forced to zero outside
  // GRANT and while reset is asserted so the bus is quiet in the reset cycle.
  always_comb begin
    o_Memory_Address = '0;
    o_Write_Enable   = 1'b0;
    o_Memory_Data    = '0;
    if ((state_q == ST_GRANT) && !i_Reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (index_q == IDX_W'(k)) begin
          o_Memory_Address = i_Address[k*ADDR_W +: ADDR_W];
          o_Write_Enable   = i_Write_Enable[k];
          o_Memory_Data    = i_Write_Data[k*DATA_W +: DATA_W];
        end
      end
    end
    o_Memory_Drive = o_Write_Enable;
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_MAX_HOLD = 4;
`else
  localparam int unsigned TB_MAX_HOLD = 16;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        grant;
  logic                      valid;
  logic [2:0]                index;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_drive;

  int unsigned tests = 0;
  int unsigned fails = 0;

  memory_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_HOLD(TB_MAX_HOLD)
  ) dut (
    .i_Clock         (clk),
    .i_Reset         (rst),
    .i_Grant_Request (req),
    .o_Grant         (grant),
    .o_Grant_Valid   (valid),
    .o_Grant_Index   (index),
    .i_Address       (addr),
    .i_Write_Enable  (we),
    .i_Write_Data    (wdata),
    .o_Memory_Address(mem_addr),
    .o_Write_Enable  (mem_we),
    .o_Memory_Data   (mem_data),
    .o_Memory_Drive  (mem_drive)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    rst   = 1'b1;
    tick(2);
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({grant, valid, index} !== 8'b0000_0_000) begin
      fails++;
      $display("FAIL reset_grant: got %b expected %b", {grant, valid, index}, 8'b0000_0_000);
    end
    tests++;
    if ({mem_addr, mem_we, mem_data, mem_drive} !== 44'h0) begin
      fails++;
      $display("FAIL reset_bus: got %h expected %h", {mem_addr, mem_we, mem_data, mem_drive}, 44'h0);
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 4'b0001;
    we = 4'b0001;
    addr[0 +: ADDR_W] = 10'h0AA;
    wdata[0 +: DATA_W] = 32'h1111_1111;
    tick(2);
    tests++;
    if ({grant, valid, index, mem_drive} !== 9'b0001_1_000_1) begin
      fails++;
      $display("FAIL midrst_pre: got %b expected %b", {grant, valid, index, mem_drive}, 9'b0001_1_000_1);
    end
    rst = 1'b1;
    tick(1);
    tests++;
    if ({grant, valid, index, mem_drive} !== 9'b0000_0_000_0) begin
      fails++;
      $display("FAIL midrst_cleared: got %b expected %b", {grant, valid, index, mem_drive}, 9'b0000_0_000_0);
    end
    tests++;
    if ({mem_addr, mem_we, mem_data} !== 43'h0) begin
      fails++;
      $display("FAIL midrst_bus: got %h expected %h", {mem_addr, mem_we, mem_data}, 43'h0);
    end
    rst = 1'b0;
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL midrst_sample: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    tick(1);
    tests++;
    if ({grant, valid, index} !== 8'b0001_1_000) begin
      fails++;
      $display("FAIL midrst_regrant: got %b expected %b", {grant, valid, index}, 8'b0001_1_000);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    addr[2*ADDR_W +: ADDR_W] = 10'h155;
    wdata[2*DATA_W +: DATA_W] = 32'hCAFE_0002;
    we = 4'b0100;
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL single_latency: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    tick(1);
    tests++;
    if ({grant, valid, index} !== 8'b0100_1_010) begin
      fails++;
      $display("FAIL single_grant: got %b expected %b", {grant, valid, index}, 8'b0100_1_010);
    end
    tests++;
    if ({mem_addr, mem_we, mem_data, mem_drive} !== {10'h155, 1'b1, 32'hCAFE_0002, 1'b1}) begin
      fails++;
      $display("FAIL single_bus: got %h expected %h", {mem_addr, mem_we, mem_data, mem_drive},
               {10'h155, 1'b1, 32'hCAFE_0002, 1'b1});
    end
    req = 4'b0000;
    tick(1);
    tests++;
    if ({grant, valid, index} !== 8'b0100_1_010) begin
      fails++;
      $display("FAIL single_drop_hold: got %b expected %b", {grant, valid, index}, 8'b0100_1_010);
    end
    tick(1);
    tests++;
    if ({grant, valid, index, mem_addr, mem_we, mem_data, mem_drive} !== 52'h0) begin
      fails++;
      $display("FAIL single_handover: got %h expected %h",
               {grant, valid, index, mem_addr, mem_we, mem_data, mem_drive}, 52'h0);
    end
    tick(1);
    tests++;
    if ({grant, valid, mem_drive} !== 6'b0000_0_0) begin
      fails++;
      $display("FAIL single_idle: got %b expected %b", {grant, valid, mem_drive}, 6'b0000_0_0);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 4'b0100;
    tick(2);
    req = 4'b0000;
    tick(1);
    req = 4'b0100;
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL b2b_handover: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL b2b_idle: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    tick(1);
    tests++;
    if ({grant, valid, index} !== 8'b0100_1_010) begin
      fails++;
      $display("FAIL b2b_regrant: got %b expected %b", {grant, valid, index}, 8'b0100_1_010);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_cur;
    logic [3:0] exp_nxt;
    apply_reset();
    req = 4'b1111;
    tick(2);
    tests++;
    if ({grant, valid, index} !== 8'b0001_1_000) begin
      fails++;
      $display("FAIL rr_first: got %b expected %b", {grant, valid, index}, 8'b0001_1_000);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      exp_cur = 4'b0001 << i;
      exp_nxt = 4'b0001 << ((i + 1) % 4);
      tick(2);
      req = 4'b1111 & ~exp_cur;
      tick(1);
      tests++;
      if (grant !== exp_cur) begin
        fails++;
        $display("FAIL rr_hold[%0d]: got %b expected %b", i, grant, exp_cur);
      end
      req = 4'b1111;
      tick(1);
      tests++;
      if ({grant, valid} !== 5'b0000_0) begin
        fails++;
        $display("FAIL rr_gap1[%0d]: got %b expected %b", i, {grant, valid}, 5'b0000_0);
      end
      tick(1);
      tests++;
      if ({grant, valid} !== 5'b0000_0) begin
        fails++;
        $display("FAIL rr_gap2[%0d]: got %b expected %b", i, {grant, valid}, 5'b0000_0);
      end
      tick(1);
      tests++;
      if ({grant, valid, index} !== {exp_nxt, 1'b1, 3'((i + 1) % 4)}) begin
        fails++;
        $display("FAIL rr_next[%0d]: got %b expected %b", i, {grant, valid, index},
                 {exp_nxt, 1'b1, 3'((i + 1) % 4)});
      end
    end
  endtask

  task automatic test_wrap_skip();
    apply_reset();
    req = 4'b0100;
    tick(2);
    req = 4'b0000;
    tick(1);
    req = 4'b0101;
    tick(3);
    tests++;
    if ({grant, valid, index} !== 8'b0001_1_000) begin
      fails++;
      $display("FAIL wrap_to_0: got %b expected %b", {grant, valid, index}, 8'b0001_1_000);
    end
    req = 4'b0100;
    tick(1);
    tests++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_hold: got %b expected %b", grant, 4'b0001);
    end
    tick(3);
    tests++;
    if ({grant, valid, index} !== 8'b0100_1_010) begin
      fails++;
      $display("FAIL skip_to_2: got %b expected %b", {grant, valid, index}, 8'b0100_1_010);
    end
  endtask

  task automatic test_transient();
    apply_reset();
    req = 4'b0001;
    tick(2);
    req = 4'b0011;
    tick(2);
    req = 4'b0001;
    tick(2);
    tests++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL transient_owner: got %b expected %b", grant, 4'b0001);
    end
    req = 4'b0000;
    tick(6);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL transient_never: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
  endtask

  task automatic test_drop_and_raise();
    apply_reset();
    req = 4'b0001;
    tick(2);
    req = 4'b0100;
    tick(1);
    tests++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL swap_hold: got %b expected %b", grant, 4'b0001);
    end
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL swap_handover: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    tick(2);
    tests++;
    if ({grant, valid, index} !== 8'b0100_1_010) begin
      fails++;
      $display("FAIL swap_new: got %b expected %b", {grant, valid, index}, 8'b0100_1_010);
    end
  endtask

  task automatic test_write_isolation();
    apply_reset();
    addr[1*ADDR_W +: ADDR_W]  = 10'h02A;
    addr[3*ADDR_W +: ADDR_W]  = 10'h3FF;
    wdata[1*DATA_W +: DATA_W] = 32'h1234_5678;
    wdata[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    we  = 4'b1000;
    req = 4'b0010;
    tick(1);
    tests++;
    if ({mem_addr, mem_we, mem_data, mem_drive} !== 44'h0) begin
      fails++;
      $display("FAIL iso_idle_bus: got %h expected %h", {mem_addr, mem_we, mem_data, mem_drive}, 44'h0);
    end
    tick(1);
    tests++;
    if ({mem_addr, mem_we, mem_data, mem_drive} !== {10'h02A, 1'b0, 32'h1234_5678, 1'b0}) begin
      fails++;
      $display("FAIL iso_other_we: got %h expected %h", {mem_addr, mem_we, mem_data, mem_drive},
               {10'h02A, 1'b0, 32'h1234_5678, 1'b0});
    end
    we = 4'b1010;
    #1;
    tests++;
    if ({mem_addr, mem_we, mem_data, mem_drive} !== {10'h02A, 1'b1, 32'h1234_5678, 1'b1}) begin
      fails++;
      $display("FAIL iso_owner_we: got %h expected %h", {mem_addr, mem_we, mem_data, mem_drive},
               {10'h02A, 1'b1, 32'h1234_5678, 1'b1});
    end
    we = 4'b0010;
    #1;
    tests++;
    if ({mem_we, mem_drive} !== 2'b11 || mem_data === 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL iso_data: got we/drive %b data %h expected 11 and not deadbeef", {mem_we, mem_drive}, mem_data);
    end
  endtask

  task automatic test_hold_limit();
`ifdef ARB_TIMEOUT_EN
    apply_reset();
    req = 4'b0011;
    tick(1);
    for (int unsigned c = 0; c < 4; c++) begin
      tick(1);
      tests++;
      if (grant !== 4'b0001) begin
        fails++;
        $display("FAIL tmo_own0[%0d]: got %b expected %b", c, grant, 4'b0001);
      end
    end
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL tmo_handover: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL tmo_idle: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      tick(1);
      tests++;
      if ({grant, index} !== 7'b0010_001) begin
        fails++;
        $display("FAIL tmo_own1[%0d]: got %b expected %b", c, {grant, index}, 7'b0010_001);
      end
    end
    tick(1);
    tests++;
    if ({grant, valid} !== 5'b0000_0) begin
      fails++;
      $display("FAIL tmo_release1: got %b expected %b", {grant, valid}, 5'b0000_0);
    end
    apply_reset();
    req = 4'b0001;
    tick(2);
    for (int unsigned c = 0; c < 20; c++) begin
      tick(1);
      tests++;
      if (grant !== 4'b0001) begin
        fails++;
        $display("FAIL tmo_alone[%0d]: got %b expected %b", c, grant, 4'b0001);
      end
    end
`else
    apply_reset();
    req = 4'b0011;
    tick(2);
    for (int unsigned c = 0; c < 24; c++) begin
      tick(1);
      tests++;
      if ({grant, valid} !== 5'b0001_1) begin
        fails++;
        $display("FAIL no_preempt[%0d]: got %b expected %b", c, {grant, valid}, 5'b0001_1);
      end
    end
`endif
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    test_reset();
    test_reset_mid_grant();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_wrap_skip();
    test_transient();
    test_drop_and_raise();
    test_write_isolation();
    test_hold_limit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
